// File: rtl/rtc_pkg.sv
// rtc_pkg: shared defaults, legal parameter ranges and the select-width helper
package rtc_pkg;
    localparam int DEF_TIME_WIDTH = 64;
    localparam int DEF_NUM_ALARMS = 4;
    localparam int MIN_TIME_WIDTH = 8;
    localparam int MAX_TIME_WIDTH = 64;
    localparam int MIN_NUM_ALARMS = 1;
    localparam int MAX_NUM_ALARMS = 8;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one compare/armed/pending alarm slot
// ALARM_PERIODIC_EN adds a period register that re-arms the slot on each match
module alarm_channel #(
    parameter int TIME_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [TIME_WIDTH-1:0] epoch_next,
    input  logic                  cmp_we,
`ifdef ALARM_PERIODIC_EN
    input  logic                  per_we,
`endif
    input  logic [TIME_WIDTH-1:0] wdata,
    input  logic                  disarm,
    input  logic                  clr,
    output logic                  armed,
    output logic                  pending
);
    logic [TIME_WIDTH-1:0] compare, next_cmp;
    logic match, reload;
    // matches are judged against the epoch value being written this edge
    assign match = armed & inc & (epoch_next == compare);
`ifdef ALARM_PERIODIC_EN
    logic [TIME_WIDTH-1:0] period;
    assign reload   = |period;
    assign next_cmp = compare + period;
    always_ff @(posedge clk or posedge rst)
        if (rst) period <= '0;
        else if (per_we) period <= wdata;
`else
    assign reload   = 1'b0;
    assign next_cmp = compare;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare <= '0;
            armed   <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (cmp_we) compare <= wdata;
            else if (match && reload) compare <= next_cmp;
            if (cmp_we) armed <= 1'b1;
            else if (disarm) armed <= 1'b0;
            else if (match) armed <= reload;
            if (match) pending <= 1'b1;
            else if (clr) pending <= 1'b0;
        end
    end
endmodule

// File: rtl/epoch_alarm_timer.sv
// epoch_alarm_timer: tick-driven epoch counter with NUM_ALARMS match alarms
// ALARM_PERIODIC_EN enables per-channel periodic reload
module epoch_alarm_timer
    import rtc_pkg::*;
#(
    parameter int  TIME_WIDTH = DEF_TIME_WIDTH,
    parameter int  NUM_ALARMS = DEF_NUM_ALARMS,
    localparam int SEL_W      = sel_width(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  count_enable,
    input  logic                  load_enable,
    input  logic [TIME_WIDTH-1:0] load_time,
    output logic [TIME_WIDTH-1:0] time_out,
    output logic                  overflow,
    input  logic                  overflow_clr,
    input  logic                  alarm_we,
    input  logic                  alarm_wperiod,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic [TIME_WIDTH-1:0] alarm_wdata,
    input  logic [NUM_ALARMS-1:0] alarm_disarm,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  irq
);
    logic tick_q, inc;
    logic [TIME_WIDTH-1:0] epoch, epoch_next;
    assign inc        = tick & ~tick_q & count_enable & ~load_enable;
    assign epoch_next = epoch + TIME_WIDTH'(1);
    assign time_out   = epoch;
    assign irq        = |alarm_pending;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q   <= 1'b0;
            epoch    <= '0;
            overflow <= 1'b0;
        end else begin
            tick_q <= tick;
            if (load_enable) epoch <= load_time;
            else if (inc) epoch <= epoch_next;
            if (inc && &epoch) overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        logic sel_hit;
        // out-of-range selects match no channel and are dropped
        assign sel_hit = alarm_we && (alarm_sel == SEL_W'(i));
        alarm_channel #(.TIME_WIDTH(TIME_WIDTH)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .inc        (inc),
            .epoch_next (epoch_next),
            .cmp_we     (sel_hit & ~alarm_wperiod),
`ifdef ALARM_PERIODIC_EN
            .per_we     (sel_hit & alarm_wperiod),
`endif
            .wdata      (alarm_wdata),
            .disarm     (alarm_disarm[i]),
            .clr        (alarm_clr[i]),
            .armed      (alarm_armed[i]),
            .pending    (alarm_pending[i])
        );
    end
endmodule

// File: tb/tb_epoch_alarm_timer.sv
// tb_epoch_alarm_timer: directed and randomized checks against a behavioural model
module tb_epoch_alarm_timer;
    localparam int W = 16, N = 3, SW = 2;
`ifdef ALARM_PERIODIC_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic tick = 1'b0, count_enable = 1'b0, load_enable = 1'b0, overflow_clr = 1'b0;
    logic alarm_we = 1'b0, alarm_wperiod = 1'b0;
    logic [W-1:0] load_time = '0, alarm_wdata = '0, time_out;
    logic [SW-1:0] alarm_sel = '0;
    logic [N-1:0] alarm_disarm = '0, alarm_clr = '0, alarm_armed, alarm_pending;
    logic overflow, irq;
    int n_chk = 0, n_fail = 0;
    logic [W-1:0] m_epoch, m_cmp[N], m_per[N];
    bit m_ovf, m_tq, m_arm[N], m_pend[N];

    epoch_alarm_timer #(.TIME_WIDTH(W), .NUM_ALARMS(N)) dut (
        .clk(clk), .rst(rst), .tick(tick), .count_enable(count_enable),
        .load_enable(load_enable), .load_time(load_time), .time_out(time_out),
        .overflow(overflow), .overflow_clr(overflow_clr), .alarm_we(alarm_we),
        .alarm_wperiod(alarm_wperiod), .alarm_sel(alarm_sel), .alarm_wdata(alarm_wdata),
        .alarm_disarm(alarm_disarm), .alarm_clr(alarm_clr), .alarm_armed(alarm_armed),
        .alarm_pending(alarm_pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_epoch = '0; m_ovf = 0; m_tq = 0;
        for (int c = 0; c < N; c++) begin
            m_cmp[c] = '0; m_per[c] = '0; m_arm[c] = 0; m_pend[c] = 0;
        end
    endtask

    // next state from the rules, evaluated with the inputs presented before the edge
    task automatic model_step();
        bit rise, step, hit, wr;
        logic [W-1:0] nx;
        if (rst) begin
            model_reset();
            return;
        end
        rise = tick && !m_tq;
        m_tq = tick;
        step = rise && count_enable && !load_enable;
        nx = m_epoch + W'(1);
        for (int c = 0; c < N; c++) begin
            hit = step && m_arm[c] && (nx == m_cmp[c]);
            wr = alarm_we && (int'(alarm_sel) == c);
            if (hit) m_pend[c] = 1;
            else if (alarm_clr[c]) m_pend[c] = 0;
            if (hit) begin
                if (PER && m_per[c] != 0) m_cmp[c] = m_cmp[c] + m_per[c];
                else m_arm[c] = 0;
            end
            if (alarm_disarm[c]) m_arm[c] = 0;
            if (wr && !alarm_wperiod) begin
                m_cmp[c] = alarm_wdata;
                m_arm[c] = 1;
            end
            if (wr && alarm_wperiod && PER) m_per[c] = alarm_wdata;
        end
        if (step && m_epoch == {W{1'b1}}) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        if (load_enable) m_epoch = load_time;
        else if (step) m_epoch = nx;
    endtask

    task automatic check_all();
        logic [N-1:0] ea, ep;
        for (int c = 0; c < N; c++) begin
            ea[c] = m_arm[c];
            ep[c] = m_pend[c];
        end
        check("time_out", time_out, m_epoch);
        check("overflow", W'(overflow), W'(m_ovf));
        check("armed", W'(alarm_armed), W'(ea));
        check("pending", W'(alarm_pending), W'(ep));
        check("irq", W'(irq), W'(|ep));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr_alarm(input int sel, input bit per, input logic [W-1:0] d);
        alarm_we = 1; alarm_wperiod = per; alarm_sel = SW'(sel); alarm_wdata = d;
        cyc();
        alarm_we = 0; alarm_wperiod = 0;
    endtask

    task automatic load(input logic [W-1:0] v);
        load_enable = 1; load_time = v;
        cyc();
        load_enable = 0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        cyc();
        rst = 0;
        cyc();
        // load then three tick rises, each visible one edge after the rise
        load(16'h0010);
        check("load", time_out, 16'h0010);
        count_enable = 1;
        for (int k = 1; k <= 3; k++) begin
            tick = 1; cyc();
            check("count", time_out, W'(16'h0010 + k));
            tick = 0; cyc();
        end
        // wrap from all-ones
        load('1);
        tick = 1; cyc();
        check("wrap_time", time_out, 16'h0000);
        check("wrap_ovf", W'(overflow), 16'h1);
        tick = 0; overflow_clr = 1; cyc();
        overflow_clr = 0;
        check("ovf_clr", W'(overflow), 16'h0);
        // one-shot match on channel 2
        wr_alarm(2, 0, 16'h0105);
        load(16'h0104);
        tick = 1; cyc();
        check("m2_pend", W'(alarm_pending[2]), 16'h1);
        check("m2_irq", W'(irq), 16'h1);
        check("m2_armed", W'(alarm_armed[2]), 16'h0);
        tick = 0; alarm_clr = 3'b100; cyc();
        alarm_clr = '0;
        check("m2_clr_irq", W'(irq), 16'h0);
        // loads never match; set beats clear
        wr_alarm(0, 0, 16'h0050);
        load(16'h0050);
        check("load_nomatch", W'(alarm_pending[0]), 16'h0);
        load(16'h004f);
        tick = 1; alarm_clr = 3'b001; cyc();
        check("set_over_clr", W'(alarm_pending[0]), 16'h1);
        tick = 0; alarm_clr = 3'b001; cyc();
        alarm_clr = '0;
        // out-of-range select is ignored
        wr_alarm(3, 0, 16'h0060);
        check("sel_oob", W'(alarm_armed), 16'h0);
        // periodic reload on channel 1 (one-shot when the feature is absent)
        wr_alarm(1, 0, 16'd10);
        wr_alarm(1, 1, 16'd5);
        load(16'd9);
        for (int e = 10; e <= 20; e++) begin
            tick = 1; cyc();
            check("periodic", W'(alarm_pending[1]), W'(e == 10 || (PER && e % 5 == 0)));
            tick = 0; alarm_clr = 3'b010; cyc();
            alarm_clr = '0;
        end
        check("periodic_armed", W'(alarm_armed[1]), W'(PER));
        // async reset mid-cycle with pending set
        wr_alarm(0, 0, time_out + W'(1));
        tick = 1; cyc();
        check("pre_rst_irq", W'(irq), 16'h1);
        #3 rst = 1;
        #1;
        model_reset();
        check_all();
        check("rst_time", time_out, 16'h0);
        // tick held high across release counts as a rise
        tick = 1; count_enable = 1;
        cyc();
        rst = 0;
        cyc();
        check("rise_after_rst", time_out, 16'h0001);
        tick = 0; cyc();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) tick = ~tick;
            count_enable = ($urandom_range(0, 9) != 0);
            load_enable = ($urandom_range(0, 29) == 0);
            load_time = ($urandom_range(0, 2) == 0) ? {W{1'b1}} - W'($urandom_range(0, 3))
                                                     : m_epoch + W'($urandom_range(0, 8));
            alarm_we = ($urandom_range(0, 7) == 0);
            alarm_wperiod = ($urandom_range(0, 3) == 0);
            alarm_sel = SW'($urandom_range(0, 3));
            alarm_wdata = alarm_wperiod ? W'($urandom_range(0, 4)) : m_epoch + W'($urandom_range(1, 6));
            alarm_disarm = ($urandom_range(0, 19) == 0) ? N'($urandom_range(1, 7)) : '0;
            alarm_clr = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 7)) : '0;
            overflow_clr = ($urandom_range(0, 9) == 0);
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/epoch_alarm_timer.md
EPOCH_ALARM_TIMER -- requirements
Module: epoch_alarm_timer

Interface
REQ-001 SHALL have parameter TIME_WIDTH, default 64, epoch counter width in bits (legal 8..64).
REQ-002 SHALL have parameter NUM_ALARMS, default 4, number of alarm channels (legal 1..8); SEL_W = max(1, clog2(NUM_ALARMS)).
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  1 Hz level from divider, synchronous to clk.
- count_enable  in  1  epoch advances on tick rise when high.
- load_enable  in  1  load load_time into epoch.
- load_time  in  TIME_WIDTH  epoch load value.
- time_out  out  TIME_WIDTH  current epoch.
- overflow  out  1  sticky epoch wrap flag.
- overflow_clr  in  1  clears overflow.
- alarm_we  in  1  write alarm_wdata to channel alarm_sel.
- alarm_wperiod  in  1  write targets period register, not compare.
- alarm_sel  in  SEL_W  target channel.
- alarm_wdata  in  TIME_WIDTH  write data.
- alarm_disarm  in  NUM_ALARMS  write-1 disarm per channel.
- alarm_clr  in  NUM_ALARMS  write-1 clear pending per channel.
- alarm_armed  out  NUM_ALARMS  channel armed.
- alarm_pending  out  NUM_ALARMS  sticky match flags.
- irq  out  1  OR of alarm_pending.

Function
REQ-004 SHALL register tick into tick_q; tick_rise = tick AND NOT tick_q.
REQ-005 SHALL, on load_enable, set epoch to load_time next cycle; load has priority over increment in the same cycle.
REQ-006 SHALL, on tick_rise with count_enable high and no load, increment epoch by 1 next cycle (1-cycle latency).
REQ-007 SHALL wrap epoch from all-ones to zero and set overflow in the same cycle; set wins over simultaneous overflow_clr.
REQ-008 SHALL, on alarm_we with alarm_wperiod low, store alarm_wdata as channel compare and set armed; pending untouched.
REQ-009 SHALL ignore alarm_we when alarm_sel >= NUM_ALARMS.
REQ-010 SHALL detect a match only on an increment: channel armed and incremented value equals compare; loads never raise a match.
REQ-011 SHALL set pending on the same edge the matching epoch value appears on time_out.
REQ-012 SHALL, on match without periodic reload, clear armed (one-shot).
REQ-013 SHALL give set priority over alarm_clr when match and clear coincide on one channel.
REQ-014 SHALL, when alarm_we hits a channel in the match cycle, evaluate the match against the old compare, then store new compare and leave armed high.
REQ-015 SHALL clear armed on alarm_disarm bit; alarm_we to the same channel in the same cycle wins.
REQ-016 SHALL drive irq combinationally as OR of alarm_pending.

Reset
REQ-017 SHALL, on rst high, asynchronously clear epoch, tick_q, overflow, all compare, period, armed and pending registers; time_out, overflow, alarm_armed, alarm_pending, irq read zero.
REQ-018 SHALL need a tick_q low-to-high after rst release before the first increment; tick held high through reset release counts as a rise.

Configuration
REQ-019 SHALL, with ALARM_PERIODIC_EN defined, implement a per-channel period register written by alarm_we with alarm_wperiod high.
REQ-020 SHALL, with ALARM_PERIODIC_EN defined and period nonzero, replace compare with compare + period (mod 2^TIME_WIDTH) on match and keep armed; zero period keeps one-shot behaviour.
REQ-021 SHALL, without ALARM_PERIODIC_EN, omit period registers, ignore writes with alarm_wperiod high, and keep all alarms one-shot.

Structure
REQ-022 SHALL place default TIME_WIDTH, default NUM_ALARMS and the legal-range constants in shared package rtc_pkg.
REQ-023 SHALL implement one channel (compare, period, armed, pending, match) as sub-module alarm_channel, instantiated NUM_ALARMS times by generate.

Verification
REQ-024 Load 0x10, count_enable=1, 3 tick rises -> time_out 0x13, each update 1 cycle after tick_rise.
REQ-025 Load all-ones, one tick rise -> time_out 0, overflow=1; overflow_clr -> overflow=0.
REQ-026 Ch2 compare=0x105, epoch 0x104, tick rise -> alarm_pending[2]=1, irq=1, armed[2]=0; alarm_clr[2] -> irq=0.
REQ-027 Ch0 compare=0x50, load 0x50 -> no pending; alarm_clr[0] in the match cycle -> pending stays 1.
REQ-028 ALARM_PERIODIC_EN: ch1 compare=10, period=5, ticks from 9 to 20 -> pending at 10, 15, 20 with clears between; armed stays 1.
REQ-029 Assert rst mid-count with pending set -> all outputs zero immediately, before next clk edge.
